// File: rtl/s1_pkg.sv
// s1_pkg: shared definitions for the stage-1 decode pipeline register.
//   - opcode constants and the I-type opcode class
//   - ALU operation encodings (raw funct[2:0] / opcode[2:0] values)
//   - instruction field bit positions
//   - s1_dec_t: decoded control fields held in each skid entry; the
//     extended immediate travels alongside it because its width is DATA_W
package s1_pkg;

    localparam int INSTR_W = 32;
    localparam int REG_W   = 5;

    localparam logic [5:0] OP_RTYPE       = 6'b000000;
    localparam logic [2:0] OP_ITYPE_CLASS = 3'b001;

    // ALU operation encodings. R-type passes funct[2:0] and I-type passes
    // opcode[2:0], so both share this numbering.
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_ADDU = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_LUI  = 3'b111;
    localparam logic [2:0] ALU_NONE = 3'b000;

    // Field bit positions
    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int IMM_MSB   = 15;
    localparam int IMM_LSB   = 0;
    localparam int FUNCT_LSB = 0;

    typedef struct packed {
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] ws;
        logic             we;
        logic             src;
        logic [2:0]       alu_op;
    } s1_dec_t;

    function automatic logic is_itype(input logic [5:0] opcode);
        return opcode[5:3] == OP_ITYPE_CLASS;
    endfunction

endpackage

// File: rtl/s1_decode_skid_reg_decode.sv
// s1_instr_decode: combinational instruction decoder.
//   instr  in   32      raw instruction word
//   dec    out  struct  register selects and ALU control
//   imm    out  DATA_W  zero-extended (I-type logical) or sign-extended immediate
module s1_instr_decode
    import s1_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output s1_dec_t            dec,
    output logic [DATA_W-1:0]  imm
);

    logic [5:0]  opcode;
    logic [15:0] imm16;
    logic        zext;

    always_comb begin
        opcode     = instr[OP_MSB:OP_LSB];
        imm16      = instr[IMM_MSB:IMM_LSB];
        zext       = 1'b0;
        dec        = '0;
        dec.alu_op = ALU_NONE;
        // Register selects are decoded for every opcode.
        dec.rs     = instr[RS_MSB:RS_LSB];
        dec.rt     = instr[RT_MSB:RT_LSB];
        if (opcode == OP_RTYPE) begin
            dec.alu_op = instr[FUNCT_LSB+2:FUNCT_LSB];
            dec.ws     = instr[RD_MSB:RD_LSB];
            dec.we     = 1'b1;
        end else if (is_itype(opcode)) begin
            dec.alu_op = opcode[2:0];
            dec.ws     = instr[RT_MSB:RT_LSB];
            dec.src    = 1'b1;
            dec.we     = 1'b1;
            // opcode[2] marks the logical group (andi/ori/xori/lui)
            zext       = opcode[2];
        end
        if (zext) imm = DATA_W'(imm16);
        else      imm = DATA_W'($signed(imm16));
    end

endmodule

// File: rtl/s1_decode_skid_reg.sv
// s1_decode_skid_reg: decode stage register with a 2-entry skid buffer.
//   clk, rst                 clock, async active-high reset
//   in_valid/in_ready/InstrIn  fetch handshake; in_ready is a flop (occ < 2)
//   flush                    drop buffered and incoming instructions
//   out_valid/out_ready      stage-2 handshake on the head entry
//   S1_*                     decoded fields of the head entry
//   stall_cnt                saturating count of out_valid & ~out_ready cycles
//
// Storage is a head register (drives the outputs directly) plus one skid
// register. The head register is only rewritten when a new entry moves into
// it, so with out_valid = 0 the outputs keep showing the last head.
module s1_decode_skid_reg
    import s1_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  InstrIn,
    input  logic                flush,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [REG_W-1:0]    S1_ReadSelect1,
    output logic [REG_W-1:0]    S1_ReadSelect2,
    output logic [REG_W-1:0]    S1_WriteSelect,
    output logic                S1_WriteEnable,
    output logic                S1_DataSrc,
    output logic [2:0]          S1_ALUOp,
    output logic [DATA_W-1:0]   S1_IMM,
    output logic [CNT_W-1:0]    stall_cnt
);

    s1_dec_t           in_dec, head_dec, skid_dec;
    logic [DATA_W-1:0] in_imm, head_imm, skid_imm;
    logic [1:0]        occ, occ_nxt;
    logic              accept, pop;
    logic              load_head, load_skid, head_from_skid;

    s1_instr_decode #(.DATA_W(DATA_W)) u_decode (
        .instr (InstrIn),
        .dec   (in_dec),
        .imm   (in_imm)
    );

    always_comb begin
        // flush wins over both handshakes
        accept         = in_valid & in_ready & ~flush;
        pop            = out_valid & out_ready & ~flush;
        occ_nxt        = occ;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        if (flush) begin
            occ_nxt = 2'd0;
        end else begin
            case (occ)
                2'd0: if (accept) begin
                    load_head = 1'b1;
                    occ_nxt   = 2'd1;
                end
                2'd1: if (accept && pop) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    load_skid = 1'b1;
                    occ_nxt   = 2'd2;
                end else if (pop) begin
                    occ_nxt = 2'd0;
                end
                default: if (pop) begin
                    // full: in_ready is low, so no accept can coincide
                    head_from_skid = 1'b1;
                    occ_nxt        = 2'd1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ       <= 2'd0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            head_dec  <= '0;
            head_imm  <= '0;
            skid_dec  <= '0;
            skid_imm  <= '0;
            stall_cnt <= '0;
        end else begin
            occ       <= occ_nxt;
            out_valid <= (occ_nxt != 2'd0);
            in_ready  <= (occ_nxt != 2'd2);
            if (load_head) begin
                head_dec <= in_dec;
                head_imm <= in_imm;
            end else if (head_from_skid) begin
                head_dec <= skid_dec;
                head_imm <= skid_imm;
            end
            if (load_skid) begin
                skid_dec <= in_dec;
                skid_imm <= in_imm;
            end
            if (out_valid && !out_ready && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign S1_ReadSelect1 = head_dec.rs;
    assign S1_ReadSelect2 = head_dec.rt;
    assign S1_WriteSelect = head_dec.ws;
    assign S1_WriteEnable = head_dec.we;
    assign S1_DataSrc     = head_dec.src;
    assign S1_ALUOp       = head_dec.alu_op;
    assign S1_IMM         = head_imm;

endmodule
